// File: rtl/lzs_pkg.sv
// Shared LZS definitions.
// Holds the widths common to the encoder output packer and the decoder
// input unpacker, and the unpacker's stream-state encoding.
package lzs_pkg;

  localparam int unsigned LZS_WORD_W   = 16;  // packed stream word
  localparam int unsigned LZS_MAXTOK_W = 13;  // longest token / peek window
  localparam int unsigned LZS_LEN_W    = 4;   // consume-length field
  localparam int unsigned LZS_BUF_W    = 32;  // unpacker bit buffer
  localparam int unsigned LZS_CNT_W    = 6;   // buffered-bit count (0..32)

  typedef enum logic [1:0] {
    RUN  = 2'd0,  // accepting words
    LAST = 2'd1,  // final word loaded, draining
    DONE = 2'd2   // stream fully consumed
  } lzs_state_e;

endpackage

// File: rtl/bit_shift_buf.sv
// MSB-aligned 32-bit bit buffer with combined shift-out and word insert.
// Ports:
//   clk, rst, ce  - clock, synchronous active-high reset, clock enable
//   shift_len     - bits consumed this cycle (already validated by caller)
//   load          - insert load_data behind the remaining bits this cycle
//   load_data     - 16-bit word, MSB first
//   buf_q         - buffer contents, valid bits at [31:32-avail_q], rest 0
//   avail_q       - number of valid bits held
//   avail_nxt     - bit count after this cycle's shift/load (for caller FSM)
module bit_shift_buf
  import lzs_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [LZS_LEN_W-1:0] shift_len,
  input  logic                 load,
  input  logic [LZS_WORD_W-1:0] load_data,
  output logic [LZS_BUF_W-1:0] buf_q,
  output logic [LZS_CNT_W-1:0] avail_q,
  output logic [LZS_CNT_W-1:0] avail_nxt
);

  logic [LZS_CNT_W-1:0] a1;
  logic [LZS_BUF_W-1:0] ins;
  logic [LZS_BUF_W-1:0] buf_nxt;

  always_comb begin
    a1  = avail_q - {2'b00, shift_len};
    ins = '0;
    // a1 <= 16 whenever a word is loaded, so the new word lands directly
    // behind the surviving bits without spilling past bit 0.
    if (load) begin
      ins = {{(LZS_BUF_W-LZS_WORD_W){1'b0}}, load_data}
            << (LZS_CNT_W'(LZS_WORD_W) - a1);
    end
    buf_nxt   = (buf_q << shift_len) | ins;
    avail_nxt = a1 + (load ? LZS_CNT_W'(LZS_WORD_W) : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q   <= '0;
      avail_q <= '0;
    end else if (ce) begin
      buf_q   <= buf_nxt;
      avail_q <= avail_nxt;
    end
  end

endmodule

// File: rtl/decode_in.sv
// LZS decompressor input bit unpacker.
// Turns the 16-bit packed word stream back into an MSB-first bit stream,
// offering the token decoder a 13-bit peek window and a 1..13 bit consume
// per cycle, plus alignment to 16-bit stream boundaries.
// Ports:
//   clk, rst, ce         - clock, synchronous active-high reset, clock enable
//   data_i/valid_i/last_i - input word, its valid, final-word flag
//   ready_o              - a word can be accepted this cycle
//   win_o                - next 13 stream bits, MSB first, zero past avail_o
//   avail_o              - buffered bit count (0..32)
//   win_valid_o          - window full, or final word loaded and bits remain
//   take_i/take_len_i    - consume take_len_i bits (0 = no-op, >13 illegal)
//   align_i              - drop bits up to the next 16-bit boundary
//   done_o               - stream fully consumed
//   err_o                - sticky over-consume / illegal-length flag
module decode_in
  import lzs_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic [LZS_WORD_W-1:0]   data_i,
  input  logic                    valid_i,
  input  logic                    last_i,
  output logic                    ready_o,
  output logic [LZS_MAXTOK_W-1:0] win_o,
  output logic [LZS_CNT_W-1:0]    avail_o,
  output logic                    win_valid_o,
  input  logic                    take_i,
  input  logic [LZS_LEN_W-1:0]    take_len_i,
  input  logic                    align_i,
  output logic                    done_o,
  output logic                    err_o
);

  lzs_state_e             state;
  lzs_state_e             state_nxt;
  logic [LZS_LEN_W-1:0]   ptr;
  logic [LZS_BUF_W-1:0]   buf_q;
  logic [LZS_CNT_W-1:0]   avail_q;
  logic [LZS_CNT_W-1:0]   avail_nxt;

  logic                   accept;
  logic                   active;
  logic                   len_bad;
  logic                   over;
  logic                   consume_ok;
  logic [LZS_LEN_W-1:0]   l_raw;
  logic [LZS_LEN_W-1:0]   l_eff;
  logic                   err_set;

  assign ready_o = (state == RUN) && (avail_q <= 6'd16) && !rst;
  assign accept  = valid_i && ready_o && ce;
  assign win_o   = buf_q[LZS_BUF_W-1 -: LZS_MAXTOK_W];
  assign avail_o = avail_q;

  always_comb begin
    active  = (state != DONE);
    // Two's-complement negate gives (16 - ptr) mod 16.
    l_raw   = '0;
    if (align_i)     l_raw = -ptr;
    else if (take_i) l_raw = take_len_i;
    len_bad    = active && take_i && !align_i && (take_len_i > 4'd13);
    over       = active && !len_bad && ({2'b00, l_raw} > avail_q);
    consume_ok = active && !len_bad && !over;
    l_eff      = consume_ok ? l_raw : '0;
    err_set    = len_bad || over;

    state_nxt = state;
    case (state)
      RUN:  if (accept && last_i) state_nxt = LAST;
      LAST: if (consume_ok && (take_i || align_i) && avail_nxt == '0)
              state_nxt = DONE;
      default: state_nxt = DONE;
    endcase
  end

  bit_shift_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .shift_len (l_eff),
    .load      (accept),
    .load_data (data_i),
    .buf_q     (buf_q),
    .avail_q   (avail_q),
    .avail_nxt (avail_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      ptr         <= '0;
      err_o       <= 1'b0;
      done_o      <= 1'b0;
      win_valid_o <= 1'b0;
    end else if (ce) begin
      state       <= state_nxt;
      ptr         <= ptr + l_eff;
      err_o       <= err_o | err_set;
      done_o      <= (state_nxt == DONE);
      win_valid_o <= (avail_nxt >= 6'd13) ||
                     ((state_nxt != RUN) && (avail_nxt != '0));
    end
  end

endmodule

// File: tb/tb_decode_in.sv
// Scoreboard bench for decode_in: stimulus pushes expected output values
// tagged with the cycle they must appear; a negedge monitor pops and checks.
module tb_decode_in;

  logic        clk = 1'b0;
  logic        rst, ce, valid_i, last_i, take_i, align_i;
  logic [15:0] data_i;
  logic [3:0]  take_len_i;
  logic        ready_o, win_valid_o, done_o, err_o;
  logic [12:0] win_o;
  logic [5:0]  avail_o;

  decode_in dut (
    .clk(clk), .rst(rst), .ce(ce), .data_i(data_i), .valid_i(valid_i),
    .last_i(last_i), .ready_o(ready_o), .win_o(win_o), .avail_o(avail_o),
    .win_valid_o(win_valid_o), .take_i(take_i), .take_len_i(take_len_i),
    .align_i(align_i), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  localparam int K_AVAIL = 0, K_WIN = 1, K_WV = 2, K_ERR = 3, K_DONE = 4, K_READY = 5;

  typedef struct {
    int    cyc;
    string name;
    int    kind;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(int k);
    case (k)
      K_AVAIL: return int'(avail_o);
      K_WIN:   return int'(win_o);
      K_WV:    return int'(win_valid_o);
      K_ERR:   return int'(err_o);
      K_DONE:  return int'(done_o);
      default: return int'(ready_o);
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      int   a;
      e = sb.pop_front();
      a = actual(e.kind);
      checks++;
      if (e.cyc != cyc || a != e.exp) begin
        failures++;
        $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", e.name, e.cyc, a, e.exp);
      end
    end
  end

  task automatic expect_at(input int dly, input string n, input int k, input int v);
    exp_t e;
    e.cyc = cyc + dly; e.name = n; e.kind = k; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 0; last_i = 0; take_i = 0; align_i = 0;
    take_len_i = 0; data_i = 0; ce = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    expect_at(0, "ready_in_rst", K_READY, 0);
    step();
    rst = 0;
  endtask

  // Reference stream for the continuous-load test.
  logic [15:0] words [20] = '{
    16'hA5C3, 16'h1234, 16'hFFFF, 16'h0000, 16'h8001, 16'h7E7E, 16'hDEAD,
    16'hBEEF, 16'h0F0F, 16'hF0F0, 16'h5555, 16'hAAAA, 16'h1357, 16'h2468,
    16'hC001, 16'h3C3C, 16'h9999, 16'h6006, 16'hFACE, 16'h0B0E};
  logic ref_bits [320];

  function automatic int ref_win(int cons, int av);
    logic [12:0] w;
    w = '0;
    for (int j = 0; j < 13; j++)
      if (j < av) w[12-j] = ref_bits[cons+j];
    return int'(w);
  endfunction

  initial begin
    int idx, m_avail, cons, a1;
    bit acc, tk;

    for (int i = 0; i < 320; i++) ref_bits[i] = words[i/16][15 - (i % 16)];

    idle_inputs();
    rst = 1;
    step();
    expect_at(0, "ready_in_rst", K_READY, 0);
    step();
    rst = 0;
    expect_at(0, "rst_avail", K_AVAIL, 0);
    expect_at(0, "rst_win", K_WIN, 0);
    expect_at(0, "rst_wv", K_WV, 0);
    expect_at(0, "rst_done", K_DONE, 0);
    expect_at(0, "rst_err", K_ERR, 0);
    expect_at(0, "rst_ready", K_READY, 1);

    // Single load then take 9.
    data_i = 16'hA5C3; valid_i = 1;
    expect_at(1, "load_avail", K_AVAIL, 16);
    expect_at(1, "load_win", K_WIN, 'h14B8);
    expect_at(1, "load_wv", K_WV, 1);
    step();
    valid_i = 0; take_i = 1; take_len_i = 9;
    expect_at(1, "take9_avail", K_AVAIL, 7);
    expect_at(1, "take9_win", K_WIN, 'h10C0);
    expect_at(1, "take9_wv", K_WV, 0);
    step();
    // Over-consume: 13 requested, 7 held.
    take_len_i = 13;
    expect_at(1, "over_err", K_ERR, 1);
    expect_at(1, "over_avail", K_AVAIL, 7);
    expect_at(1, "over_win", K_WIN, 'h10C0);
    step();
    take_i = 0;
    expect_at(1, "err_sticky", K_ERR, 1);
    step();
    rst = 1;
    expect_at(0, "ready_in_rst", K_READY, 0);
    expect_at(1, "rst_clr_err", K_ERR, 0);
    expect_at(1, "rst_clr_avail", K_AVAIL, 0);
    step();
    rst = 0;

    // ce low freezes; then two loads with take 5 on the second.
    ce = 0; data_i = 16'hFFFF; valid_i = 1;
    expect_at(1, "ce_hold_avail", K_AVAIL, 0);
    step();
    ce = 1;
    expect_at(1, "w1_avail", K_AVAIL, 16);
    step();
    data_i = 16'h0000; take_i = 1; take_len_i = 5;
    expect_at(1, "w2_avail", K_AVAIL, 27);
    expect_at(1, "w2_win", K_WIN, 'h1FFC);
    expect_at(1, "w2_ready", K_READY, 0);
    step();
    do_reset();

    // Illegal length 14.
    data_i = 16'h1234; valid_i = 1;
    step();
    valid_i = 0; take_i = 1; take_len_i = 14;
    expect_at(1, "len14_err", K_ERR, 1);
    expect_at(1, "len14_avail", K_AVAIL, 16);
    step();
    do_reset();

    // Last word, take 9, align drops 7 bits -> DONE.
    data_i = 16'h8000; valid_i = 1; last_i = 1;
    expect_at(1, "last_avail", K_AVAIL, 16);
    expect_at(1, "last_win", K_WIN, 'h1000);
    expect_at(1, "last_ready", K_READY, 0);
    step();
    valid_i = 0; last_i = 0; take_i = 1; take_len_i = 9;
    expect_at(1, "last_t9_avail", K_AVAIL, 7);
    expect_at(1, "last_t9_wv", K_WV, 1);
    expect_at(1, "last_t9_done", K_DONE, 0);
    step();
    take_i = 0; align_i = 1;
    expect_at(1, "align_avail", K_AVAIL, 0);
    expect_at(1, "align_done", K_DONE, 1);
    expect_at(1, "align_ready", K_READY, 0);
    expect_at(1, "align_wv", K_WV, 0);
    step();
    align_i = 0; valid_i = 1; data_i = 16'hFFFF; take_i = 1; take_len_i = 3;
    expect_at(1, "done_hold_avail", K_AVAIL, 0);
    expect_at(1, "done_hold_done", K_DONE, 1);
    expect_at(1, "done_no_err", K_ERR, 0);
    step();
    do_reset();

    // Reset while in LAST with 10 bits buffered.
    data_i = 16'hFFFF; valid_i = 1; last_i = 1;
    step();
    valid_i = 0; last_i = 0; take_i = 1; take_len_i = 6;
    expect_at(1, "pre_rst_avail", K_AVAIL, 10);
    expect_at(1, "pre_rst_ready", K_READY, 0);
    step();
    take_i = 0; rst = 1;
    step();
    rst = 0;
    expect_at(0, "mid_rst_avail", K_AVAIL, 0);
    expect_at(0, "mid_rst_ready", K_READY, 1);
    expect_at(0, "mid_rst_done", K_DONE, 0);
    step();

    // Continuous valid with 13-bit takes over 20 words.
    idx = 0; m_avail = 0; cons = 0;
    for (int k = 0; k < 200 && (idx < 20 || m_avail >= 13); k++) begin
      acc = (m_avail <= 16) && (idx < 20);
      tk  = (m_avail >= 13);
      valid_i = (idx < 20);
      data_i  = words[(idx < 20) ? idx : 0];
      take_i  = tk; take_len_i = 13;
      expect_at(0, "stream_ready", K_READY, (m_avail <= 16) ? 1 : 0);
      a1 = m_avail - (tk ? 13 : 0);
      m_avail = a1 + (acc ? 16 : 0);
      if (tk) cons += 13;
      if (acc) idx++;
      expect_at(1, "stream_avail", K_AVAIL, m_avail);
      expect_at(1, "stream_win", K_WIN, ref_win(cons, m_avail));
      step();
    end
    idle_inputs();
    if (idx < 20 || m_avail >= 13) begin
      checks++; failures++;
      $display("FAIL stream_budget: words_loaded=%0d required=20", idx);
    end
    expect_at(0, "stream_total", K_AVAIL, 320 - cons);
    step();
    step();

    for (int k = 0; k < 20 && sb.size() > 0; k++) step();
    if (sb.size() > 0) begin
      checks++; failures++;
      $display("FAIL sb_drain: pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
